mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single-port unified instruction/data memory of the multicycle MIPS core between two masters:
//   - m0: the CPU memory port (fetch and lw/sw accesses, address selected by IorD).
//   - m1: the program loader / DMA port.
//   Each transaction is sequenced through a fixed-latency synchronous memory.
//   The CPU FSM holds its fetch/memory state until m0_ack, so the arbiter is the CPU's only memory stall source.
// PARAMETERS
//   AW        32  address width (byte address, passed through unchanged)
//   DW        32  data width
//   MEM_LAT   2   read latency: mem_rdata valid MEM_LAT cycles after the mem_en cycle; legal range 1..15
//   ARB_MODE  0   0 = round-robin between m0/m1; 1 = fixed priority, m0 always wins
// PORTS
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous, active-low reset
//   m0_req      in   1   CPU request; held with m0_we/addr/wdata stable until m0_ack
//   m0_we       in   1   1 = write, 0 = read
//   m0_addr     in   AW  CPU address
//   m0_wdata    in   DW  CPU write data
//   m0_ack      out  1   one-cycle completion pulse to the CPU
//   m1_req      in   1   loader request; same rules as m0_req
//   m1_we       in   1   1 = write, 0 = read
//   m1_addr     in   AW  loader address
//   m1_wdata    in   DW  loader write data
//   m1_ack      out  1   one-cycle completion pulse to the loader
//   rdata       out  DW  registered read data; valid in the ack cycle of a read
//   gnt         out  2   one-hot owner of the current transaction; 00 when idle
//   mem_en      out  1   memory access strobe, exactly one cycle per transaction
//   mem_we      out  1   memory write enable (qualified by mem_en)
//   mem_addr    out  AW  memory address
//   mem_wdata   out  DW  memory write data
//   mem_rdata   in   DW  memory read data
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; gnt, m0_ack, m1_ack, mem_en, mem_we = 0; rdata, mem_addr, mem_wdata, cnt = 0; last=1 (m0 wins first).
//   FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered or decoded from state only; none depends combinationally on m*_req.
//   IDLE:
//     - No req: stay in IDLE.
//     - Otherwise select a winner:
//       - ARB_MODE=1: m0 if m0_req, else m1.
//       - ARB_MODE=0, both requesting: the master != last wins; a single requester always wins.
//     - On the edge: latch winner's we/addr/wdata; gnt<=winner; last<=winner; go to ISSUE.
//   ISSUE (cycle t): mem_en=1, mem_we/mem_addr/mem_wdata from the latched values.
//     - Write: go to DONE.
//     - Read: cnt<=MEM_LAT-1; go to WAIT.
//   WAIT: if cnt==0, rdata<=mem_rdata (sampled at end of cycle t+MEM_LAT) and go to DONE; else cnt<=cnt-1.
//   DONE: ack of gnt owner =1 for exactly this cycle; gnt held; next state IDLE (gnt<=00).
//   Latency (req first seen in IDLE at cycle r):
//     - Write: ack at r+2.
//     - Read: ack at r+MEM_LAT+2.
//     - Minimum spacing between back-to-back transactions: 1 IDLE cycle.
//   Handshake: a master must deassert req in the cycle after its ack; req still high in that IDLE cycle is a new request.
//   Losing master: its req is held unserviced; no ack, no data change.
//   Dropped req: a master dropping req mid-transaction does not abort it; the memory access completes and ack still pulses.
//   Request inputs are ignored outside IDLE.
//   Starvation: in ARB_MODE=0, with both masters continuously requesting, grants strictly alternate m0,m1,m0,...
//   rdata: holds its value until the next read capture; writes do not modify it.
//   Reset mid-transaction:
//     - Immediate IDLE, no ack issued, mem_en drops asynchronously.
//     - Any in-flight mem_rdata is discarded.
//   m0_ack and m1_ack are never high together; gnt is always 00 or one-hot.
// TESTING
//   1. Reset, then m0 read 0x0000_0040, MEM_LAT=2, memory returns 0x2008_0005:
//      mem_en exactly one cycle at r+1 with mem_we=0 -> m0_ack at r+4, rdata=0x2008_0005, gnt=01 from r+1 to r+4.
//   2. m1 write 0x0000_0100 <- 0xDEAD_BEEF:
//      mem_en=1, mem_we=1, mem_wdata=0xDEAD_BEEF at r+1 -> m1_ack at r+2; rdata unchanged.
//   3. ARB_MODE=0, both req asserted and held for 4 transactions:
//      gnt sequence 01,10,01,10 -> acks alternate m0,m1,m0,m1.
//   4. ARB_MODE=1, same stimulus:
//      m0 served every transaction while it requests; m1 served only once m0 drops req.
//   5. reset pulled low during WAIT of an m0 read:
//      mem_en=0, gnt=00, no ack -> the next m0 read after release completes normally with correct data.
//   6. MEM_LAT=1 and MEM_LAT=15 reads:
//      ack at r+3 and r+17 respectively; a master holding req one cycle past ack gets a second, distinct transaction.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two memory masters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; the master modport is the requesters plus the memory.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;

  logic [DW-1:0] rdata;
  logic [1:0]    gnt;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack,
    output rdata, gnt,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack,
    input  rdata, gnt,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a fixed-latency single-port memory: write acks at r+2, read acks at r+MEM_LAT+2.
// Losing master is stalled by holding its req unacknowledged; requests are only sampled while idle.
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 2,
  parameter int ARB_MODE = 0
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          win_m1;

  // last_q=1 means m1 was granted last, so m0 takes the first contested grant after reset.
  always_comb begin
    if (ARB_MODE == 1) begin
      win_m1 = !bus.m0_req;
    end else if (bus.m0_req && bus.m1_req) begin
      win_m1 = !last_q;
    end else begin
      win_m1 = bus.m1_req;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          gnt_d   = win_m1 ? 2'b10 : 2'b01;
          last_d  = win_m1;
          we_d    = win_m1 ? bus.m1_we    : bus.m0_we;
          addr_d  = win_m1 ? bus.m1_addr  : bus.m0_addr;
          wdata_d = win_m1 ? bus.m1_wdata : bus.m0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = bus.mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Every output is a register or a decode of the state register, never of the request inputs.
  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = (state_q == ISSUE) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.m0_ack    = (state_q == DONE) && gnt_q[0];
  assign bus.m1_ack    = (state_q == DONE) && gnt_q[1];
  assign bus.gnt       = gnt_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: four instances (latency 1/2/15, round-robin and fixed priority)
// each paired with a latency-accurate memory and a transaction-level timing model.
module tb_mem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int NINST = 4;
  localparam int NCYC  = 1200;

  logic clk = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_init(input int i);
    return (i == 0) ? 32'h2008_0005 : {16'hC0DE, 12'h000, 4'(i)};
  endfunction

  for (genvar gi = 0; gi < NINST; gi++) begin : g_inst
    localparam int LAT = (gi == 1) ? 1 : (gi == 2) ? 15 : 2;
    localparam int ARB = (gi >= 2) ? 1 : 0;

    logic        rst_n = 1'b1;
    logic [31:0] junk;
    logic [32:0] pipe [16];
    logic [31:0] mem  [16];

    mem_arbiter_if #(.AW(AW), .DW(DW)) mif ();

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .ARB_MODE(ARB)) u_dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (mif)
    );

    // Memory: read data is valid only in the cycle exactly LAT after mem_en, junk otherwise.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) begin
          mem[i]  <= mem_init(i);
          pipe[i] <= '0;
        end
        junk <= 32'h1357_9BDF;
      end else begin
        junk    <= {junk[30:0], junk[31] ^ junk[21] ^ junk[1] ^ junk[0]};
        pipe[0] <= {mif.mem_en && !mif.mem_we, mem[mif.mem_addr[5:2]]};
        for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
        if (mif.mem_en && mif.mem_we) mem[mif.mem_addr[5:2]] <= mif.mem_wdata;
      end
    end
    assign mif.mem_rdata = pipe[LAT-1][32] ? pipe[LAT-1][31:0] : junk;

    initial begin : run
      string       pfx;
      int          c, rst_at, owner, iss_c, ack_c, last, w;
      bit          busy, free, sat, do_rst, newreq;
      logic        t_we;
      logic [31:0] t_addr, t_wdata, t_rd, rd_exp;
      logic [31:0] ref_mem [16];
      bit          req [2];
      bit          pend [2];
      bit          ackd [2];
      bit          gntd [2];
      bit          wev [2];
      logic [31:0] av [2];
      logic [31:0] dv [2];
      int          nreq [2];

      pfx = $sformatf("u%0d", gi);
      for (int k = 0; k < 2; k++) begin
        req[k] = 0; pend[k] = 0; ackd[k] = 0; gntd[k] = 0;
        wev[k] = 0; av[k] = '0; dv[k] = '0; nreq[k] = 0;
      end
      mif.m0_req = 0; mif.m0_we = 0; mif.m0_addr = '0; mif.m0_wdata = '0;
      mif.m1_req = 0; mif.m1_we = 0; mif.m1_addr = '0; mif.m1_wdata = '0;
      busy = 0; last = 1; rd_exp = '0; owner = 0; iss_c = 0; ack_c = 0;
      t_we = 0; t_addr = '0; t_wdata = '0; t_rd = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = mem_init(i);

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq({pfx, ".rst_gnt"},   32'(mif.gnt), 32'd0);
      check_eq({pfx, ".rst_ack0"},  32'(mif.m0_ack), 32'd0);
      check_eq({pfx, ".rst_ack1"},  32'(mif.m1_ack), 32'd0);
      check_eq({pfx, ".rst_en"},    32'(mif.mem_en), 32'd0);
      check_eq({pfx, ".rst_we"},    32'(mif.mem_we), 32'd0);
      check_eq({pfx, ".rst_addr"},  mif.mem_addr, 32'd0);
      check_eq({pfx, ".rst_wdata"}, mif.mem_wdata, 32'd0);
      check_eq({pfx, ".rst_rdata"}, mif.rdata, 32'd0);
      rst_n  = 1'b1;
      c      = 0;
      rst_at = 200;
      do_rst = 0;

      while (c < NCYC) begin
        if (do_rst) begin
          // Asynchronous reset landing in the middle of a read's wait phase.
          rst_n = 1'b0;
          for (int k = 0; k < 2; k++) begin req[k] = 0; pend[k] = 0; end
          mif.m0_req = 0; mif.m1_req = 0;
          #1;
          check_eq({pfx, ".mid_rst_en"},   32'(mif.mem_en), 32'd0);
          check_eq({pfx, ".mid_rst_gnt"},  32'(mif.gnt), 32'd0);
          check_eq({pfx, ".mid_rst_ack0"}, 32'(mif.m0_ack), 32'd0);
          check_eq({pfx, ".mid_rst_ack1"}, 32'(mif.m1_ack), 32'd0);
          busy = 0; last = 1; rd_exp = '0;
          for (int i = 0; i < 16; i++) ref_mem[i] = mem_init(i);
          do_rst = 0;
        end else begin
          rst_n = 1'b1;
          sat = (c >= 300 && c < 500);
          for (int k = 0; k < 2; k++) begin
            newreq = 0;
            if (ackd[k]) begin
              pend[k] = 0;
              if (sat || $urandom_range(3) == 0) newreq = 1;
              else req[k] = 0;
            end else if (!pend[k]) begin
              if ((k == 0 || c >= 10) && (sat || $urandom_range(2) == 0)) newreq = 1;
            end else if (gntd[k] && !sat && $urandom_range(7) == 0) begin
              req[k] = 0;
            end
            if (newreq) begin
              req[k]  = 1;
              pend[k] = 1;
              if (nreq[k] == 0) begin
                wev[k] = (k == 1);
                av[k]  = (k == 1) ? 32'h0000_0100 : 32'h0000_0040;
                dv[k]  = (k == 1) ? 32'hDEAD_BEEF : $urandom;
              end else begin
                wev[k] = ($urandom_range(1) == 1);
                av[k]  = $urandom;
                dv[k]  = $urandom;
              end
              nreq[k]++;
            end
          end
          mif.m0_req = req[0]; mif.m0_we = wev[0]; mif.m0_addr = av[0]; mif.m0_wdata = dv[0];
          mif.m1_req = req[1]; mif.m1_we = wev[1]; mif.m1_addr = av[1]; mif.m1_wdata = dv[1];
        end

        @(negedge clk);
        ackd[0] = mif.m0_ack; ackd[1] = mif.m1_ack;
        gntd[0] = mif.gnt[0]; gntd[1] = mif.gnt[1];

        if (busy && c >= iss_c && c <= ack_c)
          check_eq({pfx, ".gnt"}, 32'(mif.gnt), (owner == 1) ? 32'd2 : 32'd1);
        else
          check_eq({pfx, ".gnt"}, 32'(mif.gnt), 32'd0);
        check_eq({pfx, ".mem_en"}, 32'(mif.mem_en), 32'(busy && c == iss_c));
        if (busy && c == iss_c) begin
          check_eq({pfx, ".mem_we"}, 32'(mif.mem_we), 32'(t_we));
          check_eq({pfx, ".mem_addr"}, mif.mem_addr, t_addr);
          if (t_we) check_eq({pfx, ".mem_wdata"}, mif.mem_wdata, t_wdata);
        end
        check_eq({pfx, ".ack0"}, 32'(mif.m0_ack), 32'(busy && c == ack_c && owner == 0));
        check_eq({pfx, ".ack1"}, 32'(mif.m1_ack), 32'(busy && c == ack_c && owner == 1));
        if (busy && c == ack_c && !t_we) rd_exp = t_rd;
        check_eq({pfx, ".rdata"}, mif.rdata, rd_exp);

        free = !busy;
        if (busy && c == ack_c) busy = 0;
        if (free && rst_n && (req[0] || req[1])) begin
          if (ARB == 1)                 w = req[0] ? 0 : 1;
          else if (req[0] && req[1])    w = (last == 0) ? 1 : 0;
          else                          w = req[0] ? 0 : 1;
          last    = w;
          owner   = w;
          busy    = 1;
          iss_c   = c + 1;
          t_we    = wev[w];
          t_addr  = av[w];
          t_wdata = dv[w];
          ack_c   = t_we ? c + 2 : c + LAT + 2;
          if (t_we) ref_mem[t_addr[5:2]] = t_wdata;
          else      t_rd = ref_mem[t_addr[5:2]];
        end

        if (c >= rst_at && busy && owner == 0 && !t_we && c >= iss_c && c + 1 < ack_c) begin
          do_rst = 1;
          rst_at = rst_at + 500;
        end

        @(posedge clk);
        #1;
        c++;
      end
      done_cnt++;
    end
  end

  initial begin
    for (int i = 0; i < 60000; i++) begin
      @(posedge clk);
      if (done_cnt == NINST) break;
    end
    check_eq("all_done", done_cnt, NINST);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
